serial_load_deserializer: RTL
=============================

// Module: serial_load_deserializer
// PURPOSE
//  Upstream feeder for the n-bit load-enable/preset register. Receives an async
//  serial frame (start, N data bits LSB-first, optional parity, stop) on rx_in,
//  oversampled by clk, and presents the word on d_out with a one-cycle ld_en
//  strobe. d_out/ld_en wire directly to the register's d/en inputs.
// PARAMETERS
//  N            8   data bits per frame; must match the downstream register width
//  CLKS_PER_BIT 16  clk cycles per serial bit; >=4, even
//  PARITY       0   0 = none, 1 = even, 2 = odd
// PORTS
//  clk         in   1  clock; all state updates on posedge
//  rst         in   1  asynchronous reset, active-low
//  rx_in       in   1  async serial line, idle high
//  d_out       out  N  last correctly received word
//  ld_en       out  1  one-cycle strobe: d_out updated this cycle
//  busy        out  1  high from start-edge detect until return to IDLE
//  frame_err   out  1  one-cycle pulse: stop bit sampled low
//  parity_err  out  1  one-cycle pulse: parity mismatch (PARITY!=0 only)
// BEHAVIOUR
//  - Reset (rst=0, async): d_out=0, ld_en=0, busy=0, frame_err=0, parity_err=0,
//    FSM=IDLE, counters=0, both synchronizer flops=1. Reset mid-frame discards
//    the partial frame; no strobe or error is produced.
//  - rx_in passes a 2-flop synchronizer (rx_s); all decisions use rx_s.
//  - FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HI.
//    IDLE: rx_s 1->0 at cycle t -> START, busy=1.
//    START: sample rx_s at t+CLKS_PER_BIT/2; 0 -> DATA; 1 -> false start, IDLE,
//      busy=0, no flags.
//    DATA: bit i (0..N-1) sampled at t+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT into
//      shift register (LSB first). After bit N-1 -> PAR if PARITY!=0, else STOP.
//    PAR: sample one CLKS_PER_BIT later; compare with XOR of data (even) or its
//      inverse (odd); result held for STOP.
//    STOP: sample one CLKS_PER_BIT later.
//      1 and parity OK -> next cycle d_out<=shift reg, ld_en=1 for exactly one
//        cycle; -> IDLE, busy=0 same cycle as ld_en.
//      1 and parity bad -> parity_err one cycle, d_out unchanged; -> IDLE.
//      0 -> frame_err one cycle (parity_err suppressed), d_out unchanged;
//        -> WAIT_HI.
//    WAIT_HI: busy=1 until rx_s=1, then IDLE; a low line never starts a frame.
//  - At most one of ld_en/frame_err/parity_err high in any cycle.
//  - Back-to-back frames: a start edge one cycle after STOP->IDLE is accepted.
//  - rx_in changes during a bit period other than at its sample point are ignored
//    (single sample at mid-bit, no majority vote).
//  - d_out holds until next good frame; never changes without ld_en.
//  - Latency: ld_en asserts 2 (sync) + 1 cycles after stop-bit mid-point on rx_in.
// TESTING  (N=8, CLKS_PER_BIT=16 unless stated)
//  1. PARITY=0, frame 0xA5 -> exactly one ld_en, d_out=0xA5, no error pulses,
//     busy low after strobe.
//  2. rx_in low for 3 clk in idle -> busy high then low by mid-start, ld_en and
//     errors never assert, d_out stays 0x00.
//  3. Good 0x5A then 0x3C frame with stop=0 -> frame_err one cycle, d_out stays
//     0x5A; rx_in held low 40 clk keeps busy=1; next good 0x11 -> d_out=0x11.
//  4. PARITY=1, 0x07 with parity bit 0 (wrong) -> parity_err one cycle, no ld_en;
//     repeat with parity 1 -> ld_en, d_out=0x07. PARITY=2, 0x07 parity 0 -> ok.
//  5. rst low during data bit 4 of 0xFF -> all outputs 0 immediately; after
//     release, frame 0x3C -> d_out=0x3C, single ld_en.
//  6. Back-to-back 0x01, 0xFF, one stop bit each -> two ld_en pulses 160 clk apart,
//     d_out 0x01 then 0xFF.

Source files
------------

// File: rtl/serial_load_deserializer.sv
// serial_load_deserializer: async serial frame receiver (start, N data LSB-first,
// optional parity, stop) that feeds a load-enable register via d_out/ld_en.
module serial_load_deserializer #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_in,
    output logic [N-1:0] d_out,
    output logic         ld_en,
    output logic         busy,
    output logic         frame_err,
    output logic         parity_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(N + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST    = BW'(N - 1);
    localparam logic          ODD     = (PARITY == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HI} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic          rx_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [N-1:0]  sh_q, sh_d, d_q, d_d;
    logic          par_ok_q, par_ok_d;
    logic          ld_q, ld_d, fe_q, fe_d, pe_q, pe_d;
    logic          rx_s, tick;

    assign rx_s = sync_q[1];
    // START waits half a bit to land on mid-bit; every later bit is a full period
    assign tick = (state_q == START) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            d_q       <= '0;
            par_ok_q  <= 1'b1;
            ld_q      <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[0], rx_in};
            rx_prev_q <= rx_s;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            d_q       <= d_d;
            par_ok_q  <= par_ok_d;
            ld_q      <= ld_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (rx_prev_q && !rx_s) ? START : IDLE;
            START:   state_d = !tick ? START : (rx_s ? IDLE : DATA);
            DATA:    state_d = (tick && bit_q == LAST) ? ((PARITY != 0) ? PAR : STOP) : DATA;
            PAR:     state_d = tick ? STOP : PAR;
            STOP:    state_d = !tick ? STOP : (rx_s ? IDLE : WAIT_HI);
            WAIT_HI: state_d = rx_s ? IDLE : WAIT_HI;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = (state_q == IDLE || state_q == WAIT_HI || tick) ? '0 : cnt_q + 1'b1;
        bit_d    = (state_q != DATA) ? '0 : (tick ? bit_q + 1'b1 : bit_q);
        sh_d     = (state_q == DATA && tick) ? {rx_s, sh_q[N-1:1]} : sh_q;
        par_ok_d = (state_q == START) ? 1'b1 :
                   (state_q == PAR && tick) ? (rx_s == (^sh_q ^ ODD)) : par_ok_q;
        ld_d     = (state_q == STOP) && tick && rx_s && par_ok_q;
        pe_d     = (state_q == STOP) && tick && rx_s && !par_ok_q;
        fe_d     = (state_q == STOP) && tick && !rx_s;
        d_d      = ld_d ? sh_q : d_q;
    end

    assign d_out      = d_q;
    assign ld_en      = ld_q;
    assign frame_err  = fe_q;
    assign parity_err = pe_q;
    assign busy       = (state_q != IDLE);
endmodule
